rr_mux_array: RTL and testbench

- Parametrised N-channel, SIZE-bit arbitrating multiplexer with valid/ready handshake on every input channel and on the output.
- Arbitration is round-robin or fixed-priority. Grants can be locked for multi-beat packets. The output has one register stage.
- Merges several datapath sources (e.g. memory-read, ALU writeback, I/O) onto one shared bus or register-file write port in the CompactRISC16 datapath.

---
 rtl/rr_mux_array.sv | 141 ++++++++++++++
 tb/tb_rr_mux_array.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_array.sv
// N-channel arbitrating multiplexer with one output register stage.
// Round-robin or fixed-priority grant, optional packet lock held until an in_last beat.
module rr_mux_array #(
  parameter int SIZE     = 16,
  parameter int CHANNELS = 4,
  parameter int RR       = 1,
  parameter int LOCK     = 0,
  localparam int CW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  input  logic [CHANNELS-1:0]      in_last,
  output logic [CHANNELS-1:0]      in_ready,
  output logic [SIZE-1:0]          out_data,
  output logic [CW-1:0]            out_chan,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Handshake: a beat moves on any edge where valid and ready are both high.
  // Upstream ready is one-hot on the granted channel and only when the output
  // register is empty or draining this cycle; valid must not wait for ready.

  logic [SIZE-1:0] ch_data [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*SIZE +: SIZE];
  end

  logic [SIZE-1:0] out_data_q, out_data_d;
  logic [CW-1:0]   out_chan_q, out_chan_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic            locked_q, locked_d;
  logic [CW-1:0]   lock_chan_q, lock_chan_d;

  logic          load;
  logic          grant_found;
  logic [CW-1:0] grant_idx;
  logic [CW-1:0] cand;
  logic [CW:0]   sum;
  logic          xfer;

  assign load = !out_valid_q || out_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sum         = '0;
    if (LOCK != 0 && locked_q) begin
      grant_idx   = lock_chan_q;
      grant_found = in_valid[lock_chan_q];
    end else if (RR != 0) begin
      // Search p, p+1, ... with wrap so the channel after the last winner goes first.
      for (int k = 0; k < CHANNELS; k++) begin
        sum = {1'b0, ptr_q} + (CW+1)'(k);
        if (sum >= (CW+1)'(CHANNELS)) sum = sum - (CW+1)'(CHANNELS);
        cand = sum[CW-1:0];
        if (!grant_found && in_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        cand = CW'(k);
        if (!grant_found && in_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign xfer = load && grant_found && !reset;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      for (int k = 0; k < CHANNELS; k++) begin
        in_ready[k] = (grant_idx == CW'(k));
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    locked_d    = locked_q;
    lock_chan_d = lock_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_chan_d  = grant_idx;
      out_last_d  = in_last[grant_idx];
      if (RR != 0) begin
        ptr_d = (grant_idx == CW'(CHANNELS-1)) ? '0 : grant_idx + CW'(1);
      end
      if (LOCK != 0) begin
        locked_d    = !in_last[grant_idx];
        lock_chan_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      locked_q    <= 1'b0;
      lock_chan_q <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      lock_chan_q <= lock_chan_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_array.sv
// Scoreboard bench for rr_mux_array: round-robin, fixed-priority and locked-packet
// instances, each with an expected-beat queue popped by its own output monitor.
module tb_rr_mux_array;

  localparam int SIZE = 16;
  localparam int CH   = 4;
  localparam int CW   = 2;
  localparam int EW   = CW + 1 + SIZE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  logic [EW-1:0] exp_q_c[$];

  // a: round-robin, b: fixed priority, c: round-robin with packet lock
  logic             a_rst, b_rst, c_rst;
  logic [CH*SIZE-1:0] a_in_data, b_in_data, c_in_data;
  logic [CH-1:0]    a_in_valid, b_in_valid, c_in_valid;
  logic [CH-1:0]    a_in_last, b_in_last, c_in_last;
  logic [CH-1:0]    a_in_ready, b_in_ready, c_in_ready;
  logic [SIZE-1:0]  a_out_data, b_out_data, c_out_data;
  logic [CW-1:0]    a_out_chan, b_out_chan, c_out_chan;
  logic             a_out_last, b_out_last, c_out_last;
  logic             a_out_valid, b_out_valid, c_out_valid;
  logic             a_out_ready, b_out_ready, c_out_ready;

  rr_mux_array #(.SIZE(SIZE), .CHANNELS(CH), .RR(1), .LOCK(0)) u_a (
    .clk(clk), .reset(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_last(a_in_last), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_last(a_out_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  rr_mux_array #(.SIZE(SIZE), .CHANNELS(CH), .RR(0), .LOCK(0)) u_b (
    .clk(clk), .reset(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_last(b_out_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  rr_mux_array #(.SIZE(SIZE), .CHANNELS(CH), .RR(1), .LOCK(1)) u_c (
    .clk(clk), .reset(c_rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_last(c_in_last), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_chan(c_out_chan), .out_last(c_out_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
  );

  function automatic logic [EW-1:0] pk(input int chan, input logic last, input logic [SIZE-1:0] data);
    return {CW'(chan), last, data};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitors: pop and compare on every accepted output beat
  always @(negedge clk) begin
    if (!a_rst && a_out_valid && a_out_ready) begin
      if (exp_q_a.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL a_unexpected: got %h expected no beat", {a_out_chan, a_out_last, a_out_data});
      end else chk("a_beat", 32'({a_out_chan, a_out_last, a_out_data}), 32'(exp_q_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_out_valid && b_out_ready) begin
      if (exp_q_b.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL b_unexpected: got %h expected no beat", {b_out_chan, b_out_last, b_out_data});
      end else chk("b_beat", 32'({b_out_chan, b_out_last, b_out_data}), 32'(exp_q_b.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!c_rst && c_out_valid && c_out_ready) begin
      if (exp_q_c.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL c_unexpected: got %h expected no beat", {c_out_chan, c_out_last, c_out_data});
      end else chk("c_beat", 32'({c_out_chan, c_out_last, c_out_data}), 32'(exp_q_c.pop_front()));
    end
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_in_valid = 4'b1111; a_in_last = '0; a_out_ready = 1'b1;
    a_in_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
    b_in_data  = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
    c_in_valid = '0; c_in_last = '0; c_out_ready = 1'b1;
    c_in_data  = '0;

    // reset with every channel requesting
    step(); step();
    @(negedge clk);
    chk("reset_out_valid", 32'(a_out_valid), 32'd0);
    chk("reset_out_data", 32'(a_out_data), 32'h0);
    chk("reset_out_chan", 32'(a_out_chan), 32'd0);
    chk("reset_out_last", 32'(a_out_last), 32'd0);
    chk("reset_in_ready", 32'(a_in_ready), 32'h0);
    chk("reset_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("reset_c_out_valid", 32'(c_out_valid), 32'd0);

    // round-robin rotation, one beat per cycle
    step();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    exp_q_a.push_back(pk(0, 1'b0, 16'h00A0));
    exp_q_a.push_back(pk(1, 1'b0, 16'h00A1));
    exp_q_a.push_back(pk(2, 1'b0, 16'h00A2));
    exp_q_a.push_back(pk(3, 1'b0, 16'h00A3));
    exp_q_a.push_back(pk(0, 1'b0, 16'h00A0));
    exp_q_a.push_back(pk(1, 1'b0, 16'h00A1));
    @(negedge clk);
    chk("rr_first_grant", 32'(a_in_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 5) a_in_valid = '0;
      @(negedge clk);
      chk("rr_back_to_back", 32'(a_out_valid), 32'd1);
    end

    // fixed priority: 1 beats 3, then 3 once 1 drops
    step();
    b_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) exp_q_b.push_back(pk(1, 1'b0, 16'h00B1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fp_ch1_wins", 32'(b_in_ready), 32'h2);
      step();
    end
    b_in_valid = 4'b1000;
    exp_q_b.push_back(pk(3, 1'b0, 16'h00B3));
    @(negedge clk);
    chk("fp_ch3_next", 32'(b_in_ready), 32'h8);
    step();
    b_in_valid = '0;

    // backpressure hold then drain-and-fill on one edge
    a_in_data[2*SIZE +: SIZE] = 16'hBEEF;
    a_in_data[0*SIZE +: SIZE] = 16'h1234;
    a_in_valid = 4'b0100;
    exp_q_a.push_back(pk(2, 1'b0, 16'hBEEF));
    step();
    a_out_ready = 1'b0;
    a_in_valid  = 4'b0001;
    exp_q_a.push_back(pk(0, 1'b0, 16'h1234));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", 32'(a_out_data), 32'hBEEF);
      chk("stall_chan", 32'(a_out_chan), 32'd2);
      chk("stall_ready", 32'(a_in_ready), 32'h0);
      chk("stall_valid", 32'(a_out_valid), 32'd1);
      step();
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("drain_fill_ready", 32'(a_in_ready), 32'h1);
    step();
    a_in_valid = '0;
    @(negedge clk);
    chk("drain_fill_valid", 32'(a_out_valid), 32'd1);
    chk("drain_fill_data", 32'(a_out_data), 32'h1234);

    // packet lock: move pointer to 1, then a 3-beat packet on channel 1
    step();
    c_in_data[0*SIZE +: SIZE] = 16'hC000;
    c_in_valid = 4'b0001; c_in_last = 4'b0001;
    exp_q_c.push_back(pk(0, 1'b1, 16'hC000));
    step();
    c_in_valid = 4'b0011;
    c_in_data[1*SIZE +: SIZE] = 16'hC101;
    exp_q_c.push_back(pk(1, 1'b0, 16'hC101));
    @(negedge clk);
    chk("lock_beat1", 32'(c_in_ready), 32'h2);
    step();
    c_in_data[1*SIZE +: SIZE] = 16'hC102;
    exp_q_c.push_back(pk(1, 1'b0, 16'hC102));
    @(negedge clk);
    chk("lock_beat2", 32'(c_in_ready), 32'h2);
    step();
    c_in_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lock_gap", 32'(c_in_ready), 32'h0);
      step();
    end
    c_in_valid = 4'b0011; c_in_last = 4'b0011;
    c_in_data[1*SIZE +: SIZE] = 16'hC103;
    exp_q_c.push_back(pk(1, 1'b1, 16'hC103));
    @(negedge clk);
    chk("lock_beat3", 32'(c_in_ready), 32'h2);
    step();
    c_in_valid = 4'b0001; c_in_last = 4'b0001;
    exp_q_c.push_back(pk(0, 1'b1, 16'hC000));
    @(negedge clk);
    chk("lock_released", 32'(c_in_ready), 32'h1);
    step();

    // reset during beat 2 of a locked packet on channel 2
    c_in_valid = 4'b0100; c_in_last = 4'b0000;
    c_in_data[2*SIZE +: SIZE] = 16'hC201;
    exp_q_c.push_back(pk(2, 1'b0, 16'hC201));
    step();
    c_rst = 1'b1;
    c_in_valid = 4'b1101; c_in_last = 4'b0001;
    c_in_data[2*SIZE +: SIZE] = 16'hC202;
    exp_q_c.delete();
    @(negedge clk);
    chk("midpkt_reset_ready", 32'(c_in_ready), 32'h0);
    step();
    @(negedge clk);
    chk("midpkt_reset_valid", 32'(c_out_valid), 32'd0);
    chk("midpkt_reset_chan", 32'(c_out_chan), 32'd0);
    c_rst = 1'b0;
    exp_q_c.push_back(pk(0, 1'b1, 16'hC000));
    #1;
    chk("midpkt_restart_ptr", 32'(c_in_ready), 32'h1);
    step();
    c_in_valid = '0;

    repeat (4) step();
    chk("a_queue_empty", 32'(exp_q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_q_b.size()), 32'd0);
    chk("c_queue_empty", 32'(exp_q_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
